// File: rtl/uart_arb_pkg.sv
// Shared types and limits for the packet-granular UART byte-channel arbiter.
package uart_arb_pkg;

    localparam int unsigned MAX_REQ = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set request scanning upward from the slot after last, modulo N_REQ.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             found
);

    int unsigned cand;

    // Scan offsets 1..N_REQ so the previous owner is considered last.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (32'(last) + i) % N_REQ;
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                pick_idx                 = cand[IDX_W-1:0];
                pick[cand[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte channel among N_REQ packet sources, round-robin per packet,
// with a watchdog that reclaims the channel from an owner that stalls mid-packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 abort_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             abort_q, abort_d;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             found;

    logic             own_valid;
    logic             own_last;
    logic [7:0]       own_data;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req      (req_valid_i),
        .last     (last_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (found)
    );

    assign own_valid = req_valid_i[owner_q];
    assign own_last  = req_last_i[owner_q];
    assign own_data  = req_data_i[8*32'(owner_q) +: 8];

    assign grant_o = grant_q;
    assign busy_o  = (state_q == GRANTED);
    assign abort_o = abort_q;

    // State, ownership, priority pointer and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

    // Next-state, watchdog and the owner-to-channel byte path.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_d        = wd_q;
        abort_d     = 1'b0;
        data_o      = '0;
        valid_o     = 1'b0;
        req_ready_o = '0;

        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (found) begin
                    state_d = GRANTED;
                    grant_d = pick;
                    owner_d = pick_idx;
                end
            end

            GRANTED: begin
                data_o               = own_data;
                valid_o              = own_valid;
                req_ready_o[owner_q] = ready_i && own_valid;
                if (own_valid) begin
                    // Valid high (stalled or moving) keeps the watchdog cleared.
                    wd_d = '0;
                    if (ready_i && own_last) begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end else if (wd_q == WD_MAX) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                    wd_d    = '0;
                    abort_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table-driven packet path plus multi-cycle corner cases.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned TO    = 16;

    logic                 clk;
    logic                 rst;
    logic [8*N_REQ-1:0]   req_data_i;
    logic [N_REQ-1:0]     req_valid_i;
    logic [N_REQ-1:0]     req_last_i;
    logic [N_REQ-1:0]     req_ready_o;
    logic [7:0]           data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [N_REQ-1:0]     grant_o;
    logic                 busy_o;
    logic                 abort_o;

    uart_tx_arbiter #(
        .N_REQ          (N_REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .abort_o     (abort_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v;
        logic [1:0] l;
        logic       r;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] er;
    } vec_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_t;

    int n_tests = 0;
    int n_fail  = 0;

    byte_t      q0[$];
    byte_t      q1[$];
    logic [7:0] log_data[$];
    int         log_src[$];
    int         grant_seq[$];
    int         gap_seq[$];
    int         zero_run;
    logic [1:0] prev_grant;
    int         abort_cnt;
    logic       rdy_drv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_trackers();
        q0.delete(); q1.delete();
        log_data.delete(); log_src.delete();
        grant_seq.delete(); gap_seq.delete();
        zero_run   = 0;
        prev_grant = '0;
        abort_cnt  = 0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        ready_i     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_trackers();
    endtask

    // One clock of the queue-fed sources; called at edge+1, returns at the next edge+1.
    task automatic tick_src();
        logic [1:0] acc;
        req_valid_i = {q1.size() != 0, q0.size() != 0};
        req_data_i  = {(q1.size() != 0) ? q1[0].data : 8'h00,
                       (q0.size() != 0) ? q0[0].data : 8'h00};
        req_last_i  = {(q1.size() != 0) ? q1[0].last : 1'b0,
                       (q0.size() != 0) ? q0[0].last : 1'b0};
        ready_i     = rdy_drv;
        #1;
        acc = req_ready_o;
        if (valid_o && ready_i) begin
            log_src.push_back(req_ready_o[1] ? 1 : 0);
            log_data.push_back(data_o);
        end
        if (abort_o) abort_cnt++;
        if (grant_o == 2'b00) zero_run++;
        else if (prev_grant == 2'b00) begin
            grant_seq.push_back(grant_o[1] ? 1 : 0);
            gap_seq.push_back(zero_run);
            zero_run = 0;
        end
        prev_grant = grant_o;
        @(posedge clk);
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        #1;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n = 0;
        while (((q0.size() != 0) || (q1.size() != 0) || busy_o) && (n < budget)) begin
            tick_src();
            n++;
        end
        chk({name, "_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    task automatic run_until_log(input string name, input int count, input int budget);
        int n = 0;
        while ((log_data.size() < count) && (n < budget)) begin
            tick_src();
            n++;
        end
        chk({name, "_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    vec_t       tbl[10];
    logic [7:0] base_exp[7];
    logic [7:0] got[$];

    initial begin
        int t;
        int exp_d;

        rst = 1'b1;
        req_valid_i = '0; req_last_i = '0; req_data_i = '0; ready_i = 1'b0;
        rdy_drv = 1'b1;
        clear_trackers();

        base_exp = '{8'h4D, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
        //            v      l      r     d0     d1     ev    ed     er
        tbl[0] = '{2'b01, 2'b00, 1'b1, 8'h4D, 8'h00, 1'b1, 8'h4D, 2'b01};
        tbl[1] = '{2'b01, 2'b00, 1'b0, 8'h30, 8'h00, 1'b1, 8'h30, 2'b00};
        tbl[2] = '{2'b11, 2'b00, 1'b1, 8'h30, 8'hEE, 1'b1, 8'h30, 2'b01};
        tbl[3] = '{2'b10, 2'b00, 1'b1, 8'h31, 8'hEE, 1'b0, 8'h31, 2'b00};
        tbl[4] = '{2'b00, 2'b00, 1'b0, 8'h31, 8'h00, 1'b0, 8'h31, 2'b00};
        tbl[5] = '{2'b01, 2'b00, 1'b1, 8'h31, 8'h00, 1'b1, 8'h31, 2'b01};
        tbl[6] = '{2'b01, 2'b00, 1'b1, 8'h32, 8'h00, 1'b1, 8'h32, 2'b01};
        tbl[7] = '{2'b01, 2'b00, 1'b1, 8'h33, 8'h00, 1'b1, 8'h33, 2'b01};
        tbl[8] = '{2'b01, 2'b00, 1'b1, 8'h0D, 8'h00, 1'b1, 8'h0D, 2'b01};
        tbl[9] = '{2'b01, 2'b01, 1'b1, 8'h0A, 8'h00, 1'b1, 8'h0A, 2'b01};

        // Reset state
        @(posedge clk); #1;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_abort", 32'(abort_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);

        // Baseline packet from requester 0, table-driven
        rst = 1'b0;
        req_valid_i = tbl[0].v; req_last_i = tbl[0].l; ready_i = tbl[0].r;
        req_data_i = {tbl[0].d1, tbl[0].d0};
        #1;
        chk("idle_grant", 32'(grant_o), 32'd0);
        chk("idle_valid", 32'(valid_o), 32'd0);
        chk("idle_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            req_valid_i = tbl[i].v; req_last_i = tbl[i].l; ready_i = tbl[i].r;
            req_data_i = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("row%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
            chk($sformatf("row%0d_data", i), 32'(data_o), 32'(tbl[i].ed));
            chk($sformatf("row%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].er));
            chk($sformatf("row%0d_grant", i), 32'(grant_o), 32'd1);
            chk($sformatf("row%0d_abort", i), 32'(abort_o), 32'd0);
            if (valid_o && ready_i) got.push_back(data_o);
            @(posedge clk); #1;
        end
        req_valid_i = '0; req_last_i = '0;
        #1;
        chk("base_end_grant", 32'(grant_o), 32'd0);
        chk("base_end_busy", 32'(busy_o), 32'd0);
        chk("base_count", 32'(got.size()), 32'd7);
        for (int i = 0; i < got.size() && i < 7; i++)
            chk($sformatf("base_byte%0d", i), 32'(got[i]), 32'(base_exp[i]));

        // Contention and fairness: both send three 3-byte packets from reset
        do_reset();
        rdy_drv = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 3; p++)
                for (int b = 0; b < 3; b++) begin
                    byte_t e;
                    e.data = 8'(k*16 + p*3 + b);
                    e.last = (b == 2);
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                end
        run_until_done("fair", 300);
        chk("fair_grants", 32'(grant_seq.size()), 32'd6);
        for (int i = 0; i < grant_seq.size() && i < 6; i++) begin
            chk($sformatf("fair_order%0d", i), 32'(grant_seq[i]), 32'(i % 2));
            chk($sformatf("fair_gap%0d", i), 32'(gap_seq[i]), 32'd1);
        end
        chk("fair_bytes", 32'(log_data.size()), 32'd18);
        for (int i = 0; i < log_data.size() && i < 18; i++) begin
            exp_d = ((i / 3) % 2) * 16 + ((i / 3) / 2) * 3 + (i % 3);
            chk($sformatf("fair_byte%0d", i), 32'(log_data[i]), 32'(exp_d));
            chk($sformatf("fair_src%0d", i), 32'(log_src[i]), 32'((i / 3) % 2));
        end

        // Backpressure: long ready stall with valid high must not trip the watchdog
        do_reset();
        rdy_drv = 1'b1;
        for (int b = 0; b < 4; b++) q0.push_back('{last: (b == 3), data: 8'(8'h50 + b)});
        run_until_log("bp_pre", 2, 20);
        rdy_drv = 1'b0;
        repeat (5000) tick_src();
        chk("bp_stall_count", 32'(log_data.size()), 32'd2);
        chk("bp_stall_grant", 32'(grant_o), 32'd1);
        chk("bp_stall_abort", 32'(abort_cnt), 32'd0);
        rdy_drv = 1'b1;
        run_until_done("bp_post", 20);
        chk("bp_count", 32'(log_data.size()), 32'd4);
        for (int i = 0; i < log_data.size() && i < 4; i++)
            chk($sformatf("bp_byte%0d", i), 32'(log_data[i]), 32'(8'h50 + i));
        chk("bp_abort", 32'(abort_cnt), 32'd0);

        // Timeout: requester 1 stalls after 2 bytes, requester 0 pending
        do_reset();
        req_valid_i = 2'b10; req_data_i = {8'hA1, 8'h00}; req_last_i = 2'b00; ready_i = 1'b1;
        #1;
        chk("to_idle_grant", 32'(grant_o), 32'd0);
        @(posedge clk); #1;
        #1;
        chk("to_grant1", 32'(grant_o), 32'd2);
        chk("to_b0_ready", 32'(req_ready_o), 32'd2);
        chk("to_b0_data", 32'(data_o), 32'hA1);
        @(posedge clk); #1;
        req_data_i = {8'hA2, 8'h00};
        #1;
        chk("to_b1_ready", 32'(req_ready_o), 32'd2);
        chk("to_b1_data", 32'(data_o), 32'hA2);
        @(posedge clk); #1;
        req_valid_i = 2'b01; req_data_i = {8'h00, 8'hB0}; req_last_i = 2'b01;
        t = -1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (t < 0) begin
                if (abort_o) begin
                    t = n;
                    chk("to_abort_grant", 32'(grant_o), 32'd0);
                end else begin
                    chk($sformatf("to_hold_grant%0d", n), 32'(grant_o), 32'd2);
                    chk($sformatf("to_hold_valid%0d", n), 32'(valid_o), 32'd0);
                end
            end else if (n == t + 1) begin
                chk("to_abort_pulse", 32'(abort_o), 32'd0);
                chk("to_regrant", 32'(grant_o), 32'd1);
                chk("to_regrant_ready", 32'(req_ready_o), 32'd1);
                chk("to_regrant_data", 32'(data_o), 32'hB0);
                break;
            end
            @(posedge clk); #1;
        end
        chk("to_latency", 32'(t), 32'd16);
        @(posedge clk); #1;
        req_valid_i = '0; req_last_i = '0;
        #1;
        chk("to_end_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;

        // Reset mid-packet, then a clean packet from requester 0 first
        do_reset();
        rdy_drv = 1'b1;
        for (int b = 0; b < 7; b++) q0.push_back('{last: (b == 6), data: 8'(8'h60 + b)});
        run_until_log("mr_pre", 3, 20);
        rst = 1'b1;
        #1;
        chk("mr_grant", 32'(grant_o), 32'd0);
        chk("mr_busy", 32'(busy_o), 32'd0);
        chk("mr_valid", 32'(valid_o), 32'd0);
        chk("mr_ready", 32'(req_ready_o), 32'd0);
        chk("mr_data", 32'(data_o), 32'd0);
        chk("mr_abort", 32'(abort_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_trackers();
        for (int b = 0; b < 4; b++) q0.push_back('{last: (b == 3), data: 8'(8'h70 + b)});
        for (int b = 0; b < 2; b++) q1.push_back('{last: (b == 1), data: 8'(8'h80 + b)});
        run_until_done("mr_post", 50);
        chk("mr_grants", 32'(grant_seq.size()), 32'd2);
        if (grant_seq.size() > 0) chk("mr_first_owner", 32'(grant_seq[0]), 32'd0);
        chk("mr_count", 32'(log_data.size()), 32'd6);
        for (int i = 0; i < log_data.size() && i < 6; i++)
            chk($sformatf("mr_byte%0d", i), 32'(log_data[i]),
                (i < 4) ? 32'(8'h70 + i) : 32'(8'h80 + i - 4));
        chk("mr_abort_cnt", 32'(abort_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

endmodule
